decoder_scan_seq: RTL and testbench

Parametrised, registered one-hot decoder with a built-in scan sequencer, successor to the fixed 4-to-16 combinational decoder. It drives 2^SEL_W one-hot select lines (row/column strobes, chip-selects, LED digit enables). The selected line is either loaded directly from a command or auto-stepped up or down with a programmable dwell time. Commands arrive over a valid/ready handshake.

---
 rtl/decoder_scan_seq_if.sv | 27 ++
 rtl/decoder_scan_seq.sv | 116 +++++++++++
 tb/tb_decoder_scan_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_seq_if.sv
// Command channel for decoder_scan_seq.
//   in_valid : command valid (master -> slave)
//   in_ready : command accept (slave -> master)
//   in_mode  : 0 OFF, 1 DIRECT, 2 SCAN_UP, 3 SCAN_DN
//   in_sel   : index for DIRECT, start index for scans
interface decoder_scan_seq_if #(
  parameter int unsigned SEL_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [SEL_W-1:0] in_sel;

  modport master (
    output in_valid,
    output in_mode,
    output in_sel,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_mode,
    input  in_sel,
    output in_ready
  );
endinterface

// File: rtl/decoder_scan_seq.sv
// Registered one-hot decoder with a built-in scan sequencer.
// Drives 2^SEL_W one-hot select lines, either loaded directly from a command
// or auto-stepped up/down, holding each index for DWELL cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : global enable; low freezes all state and forces wrap low
//   cmd        : valid/ready command channel (slave side)
//   y          : registered one-hot select, zero when OFF
//   y_active   : high when y is non-zero
//   cur_idx    : currently selected index
//   wrap       : one-cycle pulse in the cycle y first shows a wrapped index
module decoder_scan_seq #(
  parameter int unsigned SEL_W = 4,
  parameter int unsigned DWELL = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  decoder_scan_seq_if.slave       cmd,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic                    y_active,
  output logic [SEL_W-1:0]        cur_idx,
  output logic                    wrap
);

  localparam int unsigned N    = 1 << SEL_W;
  localparam int unsigned CntW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CntW-1:0]  CntMax = CntW'(DWELL - 1);
  localparam logic [SEL_W-1:0] IdxMax = SEL_W'(N - 1);

  typedef enum logic [1:0] {
    StOff    = 2'd0,
    StDirect = 2'd1,
    StScanUp = 2'd2,
    StScanDn = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wrap_q, wrap_d;
  logic [N-1:0]     y_q, y_d;
  logic             active_q, active_d;
  logic             accept;

  assign cmd.in_ready = en;
  assign accept       = cmd.in_valid & en;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;

    if (en) begin
      if (accept) begin
        // A command always wins over a step scheduled in the same cycle.
        state_d = state_e'(cmd.in_mode);
        idx_d   = (state_e'(cmd.in_mode) == StOff) ? '0 : cmd.in_sel;
        cnt_d   = '0;
      end else begin
        unique case (state_q)
          StScanUp: begin
            if (cnt_q == CntMax) begin
              cnt_d  = '0;
              idx_d  = idx_q + SEL_W'(1);
              wrap_d = (idx_q == IdxMax);
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StScanDn: begin
            if (cnt_q == CntMax) begin
              cnt_d  = '0;
              idx_d  = idx_q - SEL_W'(1);
              wrap_d = (idx_q == '0);
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          default: ;
        endcase
      end
    end

    // Outputs are decoded from next state so they register in step with it.
    y_d      = '0;
    active_d = (state_d != StOff);
    if (active_d) begin
      y_d[idx_d] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StOff;
      idx_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      y_q      <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      wrap_q   <= wrap_d;
      y_q      <= y_d;
      active_q <= active_d;
    end
  end

  assign y        = y_q;
  assign y_active = active_q;
  assign cur_idx  = idx_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Directed bench for decoder_scan_seq: one instance with DWELL=3 and one
// with DWELL=1, both SEL_W=4.
module tb_decoder_scan_seq;

  localparam logic [1:0] MOff = 2'd0, MDir = 2'd1, MUp = 2'd2, MDn = 2'd3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  int          n_vec = 0;
  int          n_err = 0;

  logic [15:0] y0, y1;
  logic        act0, act1, wrap0, wrap1;
  logic [3:0]  idx0, idx1;

  decoder_scan_seq_if #(.SEL_W(4)) cmd0 ();
  decoder_scan_seq_if #(.SEL_W(4)) cmd1 ();

  decoder_scan_seq #(.SEL_W(4), .DWELL(3)) dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cmd      (cmd0),
    .y        (y0),
    .y_active (act0),
    .cur_idx  (idx0),
    .wrap     (wrap0)
  );

  decoder_scan_seq #(.SEL_W(4), .DWELL(1)) dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .cmd      (cmd1),
    .y        (y1),
    .y_active (act1),
    .cur_idx  (idx1),
    .wrap     (wrap1)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic [1:0] mode, input logic [3:0] sel);
    cmd0.in_valid = 1'b1;
    cmd0.in_mode  = mode;
    cmd0.in_sel   = sel;
    tick();
    cmd0.in_valid = 1'b0;
  endtask

  task automatic send1(input logic [1:0] mode, input logic [3:0] sel);
    cmd1.in_valid = 1'b1;
    cmd1.in_mode  = mode;
    cmd1.in_sel   = sel;
    tick();
    cmd1.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({y0, act0, idx0, wrap0} !== 22'd0) begin
      n_err++;
      $display("FAIL reset_state: got y=%h act=%b idx=%0d wrap=%b, want all zero",
               y0, act0, idx0, wrap0);
    end
    n_vec++;
    if (cmd0.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 0", cmd0.in_ready);
    end
    #10;
    rst_n = 1'b1;
    en    = 1'b1;
    tick();
    n_vec++;
    if ({y0, act0} !== 17'd0 || cmd0.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_reset: got y=%h act=%b rdy=%b, want y=0 act=0 rdy=1",
               y0, act0, cmd0.in_ready);
    end
  endtask

  task automatic test_direct();
    logic [15:0] exp_y;
    for (int i = 0; i < 16; i++) begin
      send0(MDir, 4'(i));
      exp_y = 16'h0001 << i;
      n_vec++;
      if (y0 !== exp_y || act0 !== 1'b1 || idx0 !== 4'(i)) begin
        n_err++;
        $display("FAIL direct_%0d: got y=%h act=%b idx=%0d, want y=%h act=1 idx=%0d",
                 i, y0, act0, idx0, exp_y, i);
      end
    end
  endtask

  task automatic test_scan_up_wrap();
    logic [15:0] exp_y [10];
    logic        exp_w [10];
    exp_y = '{16'h4000, 16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h8000,
              16'h0001, 16'h0001, 16'h0001, 16'h0002};
    exp_w = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    send0(MUp, 4'd14);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      n_vec++;
      if (y0 !== exp_y[i] || wrap0 !== exp_w[i]) begin
        n_err++;
        $display("FAIL scan_up_%0d: got y=%h wrap=%b, want y=%h wrap=%b",
                 i, y0, wrap0, exp_y[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_scan_dn_dwell1();
    logic [15:0] exp_y [4];
    logic        exp_w [4];
    exp_y = '{16'h0002, 16'h0001, 16'h8000, 16'h4000};
    exp_w = '{0, 0, 1, 0};
    send1(MDn, 4'd1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      n_vec++;
      if (y1 !== exp_y[i] || wrap1 !== exp_w[i]) begin
        n_err++;
        $display("FAIL scan_dn_d1_%0d: got y=%h wrap=%b, want y=%h wrap=%b",
                 i, y1, wrap1, exp_y[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_freeze_resume();
    logic [15:0] exp_y [3];
    exp_y = '{16'h0020, 16'h0020, 16'h0040};
    send0(MUp, 4'd5);
    n_vec++;
    if (y0 !== 16'h0020) begin
      n_err++;
      $display("FAIL freeze_start: got y=%h want 0020", y0);
    end
    en = 1'b0;
    // A command offered while disabled must be dropped.
    cmd0.in_valid = 1'b1;
    cmd0.in_mode  = MDir;
    cmd0.in_sel   = 4'd0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (y0 !== 16'h0020 || cmd0.in_ready !== 1'b0 || wrap0 !== 1'b0) begin
        n_err++;
        $display("FAIL freeze_%0d: got y=%h rdy=%b wrap=%b, want y=0020 rdy=0 wrap=0",
                 i, y0, cmd0.in_ready, wrap0);
      end
    end
    cmd0.in_valid = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (y0 !== exp_y[i]) begin
        n_err++;
        $display("FAIL resume_%0d: got y=%h want %h", i, y0, exp_y[i]);
      end
    end
  endtask

  task automatic test_collision();
    send0(MUp, 4'd15);
    tick();
    tick();
    n_vec++;
    if (y0 !== 16'h8000) begin
      n_err++;
      $display("FAIL collision_pre: got y=%h want 8000", y0);
    end
    // Step (and wrap) is due at this edge; the command must win.
    send0(MDir, 4'd9);
    n_vec++;
    if (y0 !== 16'h0200 || wrap0 !== 1'b0 || idx0 !== 4'd9) begin
      n_err++;
      $display("FAIL collision: got y=%h wrap=%b idx=%0d, want y=0200 wrap=0 idx=9",
               y0, wrap0, idx0);
    end
    tick();
    tick();
    n_vec++;
    if (y0 !== 16'h0200 || wrap0 !== 1'b0) begin
      n_err++;
      $display("FAIL direct_hold: got y=%h wrap=%b, want y=0200 wrap=0", y0, wrap0);
    end
    send0(MOff, 4'd7);
    n_vec++;
    if (y0 !== 16'h0000 || idx0 !== 4'd0 || act0 !== 1'b0) begin
      n_err++;
      $display("FAIL off_cmd: got y=%h idx=%0d act=%b, want y=0 idx=0 act=0",
               y0, idx0, act0);
    end
  endtask

  task automatic test_reset_mid();
    send0(MUp, 4'd3);
    send1(MUp, 4'd15);
    tick();
    n_vec++;
    if (wrap1 !== 1'b1 || y1 !== 16'h0001 || y0 !== 16'h0008) begin
      n_err++;
      $display("FAIL pre_reset: got y0=%h y1=%h wrap1=%b, want y0=0008 y1=0001 wrap1=1",
               y0, y1, wrap1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({y0, act0, idx0, wrap0} !== 22'd0 || {y1, act1, idx1, wrap1} !== 22'd0) begin
      n_err++;
      $display("FAIL async_reset: got y0=%h idx0=%0d y1=%h idx1=%0d wrap1=%b, want zeros",
               y0, idx0, y1, idx1, wrap1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++;
      if (y0 !== 16'h0 || act0 !== 1'b0 || y1 !== 16'h0) begin
        n_err++;
        $display("FAIL post_reset_%0d: got y0=%h act0=%b y1=%h, want zeros",
                 i, y0, act0, y1);
      end
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    en            = 1'b0;
    cmd0.in_valid = 1'b0;
    cmd0.in_mode  = MOff;
    cmd0.in_sel   = '0;
    cmd1.in_valid = 1'b0;
    cmd1.in_mode  = MOff;
    cmd1.in_sel   = '0;
    test_reset();
    test_direct();
    test_scan_up_wrap();
    test_scan_dn_dwell1();
    test_freeze_resume();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
